// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Load/store access length encoding.
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // Address bits [IO_SEL_HI:IO_SEL_HI-1] equal to this select the I/O region.
    localparam logic [1:0] IO_REGION = 2'b11;

    // Number of byte beats for a load/store length code (illegal 11 treated as a word).
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store onto a single 8-bit memory bus.
// Each access is split into byte beats; read bytes return one cycle after their
// address and are assembled little-endian. Requests are level handshakes: a
// requester raises req with stable operands and holds it until it sees its
// one-cycle done pulse; the controller never acknowledges before done.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [31:0]       if_data_out,
    input  logic              ls_req_in,
    input  logic              ls_wr_in,
    input  logic [1:0]        ls_len_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [31:0]       ls_wdata_in,
    output logic              ls_done_out,
    output logic [31:0]       ls_rdata_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    output logic [1:0]        dbg_state_out
);

    state_e            state_q, state_d;
    logic              last_ls_q, last_ls_d;     // previous grant went to load/store
    logic              own_ls_q, own_ls_d;       // current transaction belongs to load/store
    logic [2:0]        n_q, n_d;                 // beats in the transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        issue_q, issue_d;         // beats placed on the bus so far
    logic [1:0]        rcv_q, rcv_d;             // read bytes already captured
    logic              bus_v_q, bus_v_d;         // a read beat is on the bus this cycle
    logic              samp_v_q, samp_v_d;       // mem_din carries byte rcv_q this cycle
    logic              restart_q, restart_d;     // read interrupted by rdy_in, replay from byte 0
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic              gnt_ls, gnt_rd, gnt_go, gnt_io;
    logic [ADDR_W-1:0] gnt_addr, beat_addr;
    logic              beat_io, rd_last, wr_last;
    logic [7:0]        beat_byte;
    logic [31:0]       asm_data;

    // Arbitration and per-beat helper values.
    always_comb begin
        gnt_ls    = ls_req_in && !(last_ls_q && if_req_in);
        gnt_rd    = gnt_ls ? !ls_wr_in : 1'b1;
        gnt_go    = (state_q == ST_IDLE) && rdy_in && (ls_req_in || if_req_in)
                    && !(clear_in && gnt_rd);
        gnt_addr  = gnt_ls ? ls_addr_in : if_addr_in;
        gnt_io    = (gnt_addr[IO_SEL_HI -: 2] == IO_REGION);
        beat_addr = addr_q + ADDR_W'(issue_q);
        beat_io   = (beat_addr[IO_SEL_HI -: 2] == IO_REGION);
        case (issue_q[1:0])
            2'd0:    beat_byte = wdata_q[7:0];
            2'd1:    beat_byte = wdata_q[15:8];
            2'd2:    beat_byte = wdata_q[23:16];
            default: beat_byte = wdata_q[31:24];
        endcase
        asm_data = data_q | ({24'd0, mem_din} << {rcv_q, 3'b000});
        rd_last  = samp_v_q && ({1'b0, rcv_q} == (n_q - 3'd1));
        wr_last  = (issue_q == n_q);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_go) state_d = gnt_rd ? ST_READ : ST_WRITE;
            end
            ST_READ: begin
                if (clear_in) state_d = ST_IDLE;
                else if (rdy_in && !restart_q && rd_last) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (rdy_in && wr_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        last_ls_d  = last_ls_q;
        own_ls_d   = own_ls_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        issue_d    = issue_q;
        rcv_d      = rcv_q;
        bus_v_d    = bus_v_q;
        samp_v_d   = samp_v_q;
        restart_d  = restart_q;
        data_d     = data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            ST_IDLE: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
                if (gnt_go) begin
                    last_ls_d = gnt_ls;
                    own_ls_d  = gnt_ls;
                    n_d       = gnt_ls ? len_to_n(ls_len_in) : 3'd4;
                    addr_d    = gnt_addr;
                    wdata_d   = ls_wdata_in;
                    rcv_d     = 2'd0;
                    samp_v_d  = 1'b0;
                    restart_d = 1'b0;
                    data_d    = '0;
                    if (gnt_rd) begin
                        mem_a_d = gnt_addr;
                        issue_d = 3'd1;
                        bus_v_d = 1'b1;
                    end else if (gnt_io && io_buffer_full) begin
                        issue_d = 3'd0;
                        bus_v_d = 1'b0;
                    end else begin
                        mem_a_d    = gnt_addr;
                        mem_dout_d = ls_wdata_in[7:0];
                        mem_wr_d   = 1'b1;
                        issue_d    = 3'd1;
                        bus_v_d    = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (clear_in) begin
                    mem_a_d  = '0;
                    bus_v_d  = 1'b0;
                    samp_v_d = 1'b0;
                end else if (!rdy_in) begin
                    restart_d = 1'b1;
                end else if (restart_q) begin
                    // Bus was lent out; bytes in flight are lost, so replay from byte 0.
                    restart_d = 1'b0;
                    mem_a_d   = addr_q;
                    issue_d   = 3'd1;
                    bus_v_d   = 1'b1;
                    samp_v_d  = 1'b0;
                    rcv_d     = 2'd0;
                    data_d    = '0;
                end else begin
                    samp_v_d = bus_v_q;
                    if (samp_v_q) begin
                        data_d = asm_data;
                        rcv_d  = rcv_q + 2'd1;
                        if (rd_last) begin
                            if (own_ls_q) begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = asm_data;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = asm_data;
                            end
                        end
                    end
                    if (issue_q < n_q) begin
                        mem_a_d = beat_addr;
                        issue_d = issue_q + 3'd1;
                        bus_v_d = 1'b1;
                    end else begin
                        mem_a_d = '0;
                        bus_v_d = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                // With rdy_in low the beat on the bus is held and re-driven later.
                if (rdy_in) begin
                    if (wr_last) begin
                        ls_done_d = 1'b1;
                        mem_a_d   = '0;
                        mem_wr_d  = 1'b0;
                    end else if (beat_io && io_buffer_full) begin
                        mem_a_d  = '0;
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_a_d    = beat_addr;
                        mem_dout_d = beat_byte;
                        mem_wr_d   = 1'b1;
                        issue_d    = issue_q + 3'd1;
                    end
                end
            end
            default: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_ls_q  <= 1'b0;
            own_ls_q   <= 1'b0;
            n_q        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            issue_q    <= 3'd0;
            rcv_q      <= 2'd0;
            bus_v_q    <= 1'b0;
            samp_v_q   <= 1'b0;
            restart_q  <= 1'b0;
            data_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            last_ls_q  <= last_ls_d;
            own_ls_q   <= own_ls_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            issue_q    <= issue_d;
            rcv_q      <= rcv_d;
            bus_v_q    <= bus_v_d;
            samp_v_q   <= samp_v_d;
            restart_q  <= restart_d;
            data_q     <= data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // The write strobe is dropped immediately while the host owns the bus.
    assign mem_wr        = mem_wr_q & rdy_in;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign if_done_out   = if_done_q;
    assign if_data_out   = if_data_q;
    assign ls_done_out   = ls_done_q;
    assign ls_rdata_out  = ls_rdata_q;
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-memory model and expected-result queues.
module tb_mem_ctrl;

    typedef struct packed {
        logic        is_wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
    } ls_exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ls_req_in, ls_wr_in;
    logic [1:0]  ls_len_in;
    logic [31:0] ls_addr_in, ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] ls_rdata_out;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [1:0]  dbg_state_out;

    int checks = 0;
    int failures = 0;
    int if_left = 0;
    int ls_left = 0;
    logic [31:0] exp_if_q[$];
    ls_exp_t     exp_ls_q[$];
    logic        order_q[$];   // 1 = load/store done, 0 = fetch done
    logic [7:0]  io_q[$];
    logic [7:0]  ram[int];

    mem_ctrl #(.ADDR_W(32), .IO_SEL_HI(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_req_in(ls_req_in), .ls_wr_in(ls_wr_in), .ls_len_in(ls_len_in),
        .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
        .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state_out(dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h000: return 8'h11;
            32'h001: return 8'h22;
            32'h002: return 8'h33;
            32'h003: return 8'h44;
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h301: return 8'h80;
            32'h302: return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a[11:0]);
        if (ram.exists(k)) return ram[k];
        return init_byte(k);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [1:0] len);
        logic [31:0] w;
        w = {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
        if (len == 2'b00) w = w & 32'h0000_00FF;
        else if (len == 2'b01) w = w & 32'h0000_FFFF;
        return w;
    endfunction

    // Memory: read byte valid one cycle after its address; random while the host owns the bus.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= mem_rd(mem_a);
        else        mem_din <= 8'($urandom_range(0, 255));
        if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) io_q.push_back(mem_dout);
            else ram[int'(mem_a[11:0])] = mem_dout;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance until all pending requests complete, scoring every done pulse.
    task automatic run_txns(input int budget, output int if_cyc, output int ls_cyc);
        int c;
        ls_exp_t e;
        c = 0;
        if_cyc = -1;
        ls_cyc = -1;
        while ((if_left > 0 || ls_left > 0) && c < budget) begin
            tick();
            c++;
            if (if_done_out) begin
                if (if_cyc < 0) if_cyc = c;
                order_q.push_back(1'b0);
                check("if_sb_pending", 32'(exp_if_q.size() > 0), 32'd1);
                if (exp_if_q.size() > 0) check("if_data", if_data_out, exp_if_q.pop_front());
                if (if_left > 0) if_left--;
                if (if_left == 0) if_req_in = 1'b0;
            end
            if (ls_done_out) begin
                if (ls_cyc < 0) ls_cyc = c;
                order_q.push_back(1'b1);
                check("ls_sb_pending", 32'(exp_ls_q.size() > 0), 32'd1);
                if (exp_ls_q.size() > 0) begin
                    e = exp_ls_q.pop_front();
                    if (e.is_wr) check("ls_wr_mem", mem_word(e.addr, e.len), e.data);
                    else         check("ls_rdata", ls_rdata_out, e.data);
                end
                if (ls_left > 0) ls_left--;
                if (ls_left == 0) ls_req_in = 1'b0;
            end
        end
        check("txn_remaining", 32'(if_left + ls_left), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_if_done"}, 32'(if_done_out), 32'd0);
        check({tag, "_ls_done"}, 32'(ls_done_out), 32'd0);
        check({tag, "_if_data"}, if_data_out, 32'd0);
        check({tag, "_ls_rdata"}, ls_rdata_out, 32'd0);
    endtask

    initial begin
        int if_cyc, ls_cyc, ndone;
        logic [3:0] ord;
        logic found;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0;
        ls_req_in = 1'b0; ls_wr_in = 1'b0; ls_len_in = 2'b00; ls_addr_in = '0; ls_wdata_in = '0;
        repeat (3) tick();
        check_all_zero("reset");
        check("reset_state", 32'(dbg_state_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // Word fetch: done six cycles after grant.
        if_addr_in = 32'h100; if_req_in = 1'b1; if_left = 1;
        exp_if_q.push_back(32'h0000_0513);
        run_txns(20, if_cyc, ls_cyc);
        check("fetch_latency", if_cyc, 32'd6);
        tick(); tick();
        check("if_done_is_pulse", 32'(if_done_out), 32'd0);
        check("if_data_hold", if_data_out, 32'h0000_0513);

        // Simultaneous store and fetch after a fetch grant: store goes first.
        ls_wr_in = 1'b1; ls_len_in = 2'b10; ls_addr_in = 32'h200; ls_wdata_in = 32'hDEAD_BEEF;
        ls_req_in = 1'b1; ls_left = 1;
        exp_ls_q.push_back('{is_wr: 1'b1, len: 2'b10, addr: 32'h200, data: 32'hDEAD_BEEF});
        if_addr_in = 32'h0; if_req_in = 1'b1; if_left = 1;
        exp_if_q.push_back(32'h4433_2211);
        run_txns(40, if_cyc, ls_cyc);
        check("store_latency", ls_cyc, 32'd5);
        check("fetch_after_store", if_cyc, 32'd11);

        // Fairness: both requesters held high, grants alternate starting with load/store.
        order_q.delete();
        ls_wr_in = 1'b0; ls_len_in = 2'b00; ls_addr_in = 32'h301; ls_req_in = 1'b1; ls_left = 2;
        repeat (2) exp_ls_q.push_back('{is_wr: 1'b0, len: 2'b00, addr: 32'h301, data: 32'h0000_0080});
        if_addr_in = 32'h100; if_req_in = 1'b1; if_left = 2;
        repeat (2) exp_if_q.push_back(32'h0000_0513);
        run_txns(80, if_cyc, ls_cyc);
        check("fair_count", 32'(order_q.size()), 32'd4);
        ord = 4'b0000;
        for (int i = 0; i < 4 && i < order_q.size(); i++) ord[3-i] = order_q[i];
        check("fair_order", 32'(ord), 32'h0000_000A);

        // Halfword read with the sign bit set: zero-extended, done in cycle 4.
        ls_wr_in = 1'b0; ls_len_in = 2'b01; ls_addr_in = 32'h301; ls_req_in = 1'b1; ls_left = 1;
        exp_ls_q.push_back('{is_wr: 1'b0, len: 2'b01, addr: 32'h301, data: 32'h0000_FF80});
        run_txns(20, if_cyc, ls_cyc);
        check("half_latency", ls_cyc, 32'd4);

        // I/O byte write held off while the output buffer is full.
        io_q.delete();
        io_buffer_full = 1'b1;
        ls_wr_in = 1'b1; ls_len_in = 2'b00; ls_addr_in = 32'h0003_0000; ls_wdata_in = 32'h0000_0041;
        ls_req_in = 1'b1;
        tick();
        check("io_stall_c1_wr", 32'(mem_wr), 32'd0);
        check("io_stall_c1_a", mem_a, 32'd0);
        tick();
        check("io_stall_c2_wr", 32'(mem_wr), 32'd0);
        tick();
        io_buffer_full = 1'b0;
        check("io_stall_c3_wr", 32'(mem_wr), 32'd0);
        tick();
        check("io_beat_wr", 32'(mem_wr), 32'd1);
        check("io_beat_a", mem_a, 32'h0003_0000);
        check("io_beat_dout", 32'(mem_dout), 32'h41);
        tick();
        check("io_done", 32'(ls_done_out), 32'd1);
        ls_req_in = 1'b0;
        check("io_beats", 32'(io_q.size()), 32'd1);
        if (io_q.size() > 0) check("io_byte", 32'(io_q[0]), 32'h41);

        // Bus lent to the host mid-fetch: read replays from byte 0 and data is intact.
        if_addr_in = 32'h100; if_req_in = 1'b1; if_left = 1;
        exp_if_q.push_back(32'h0000_0513);
        tick(); tick();
        rdy_in = 1'b0;
        tick(); tick();
        rdy_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_a == 32'h100) found = 1'b1;
        end
        check("freeze_restart_byte0", 32'(found), 32'd1);
        run_txns(20, if_cyc, ls_cyc);

        // Flush mid-fetch: bus idle next cycle and no done pulse ever.
        if_addr_in = 32'h100; if_req_in = 1'b1;
        tick(); tick(); tick();
        clear_in = 1'b1; if_req_in = 1'b0;
        tick();
        clear_in = 1'b0;
        check("clear_bus_a", mem_a, 32'd0);
        check("clear_bus_wr", 32'(mem_wr), 32'd0);
        check("clear_state", 32'(dbg_state_out), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_done_out) ndone++;
        end
        check("clear_no_done", ndone, 32'd0);

        // Reset in the middle of a word write.
        ls_wr_in = 1'b1; ls_len_in = 2'b10; ls_addr_in = 32'h210; ls_wdata_in = 32'h1234_5678;
        ls_req_in = 1'b1;
        tick(); tick();
        check("midwrite_active", 32'(mem_wr), 32'd1);
        rst_in = 1'b1; ls_req_in = 1'b0;
        tick();
        check_all_zero("midwrite_reset");
        rst_in = 1'b0;
        tick();

        // After reset the last grant is fetch, so load/store wins a tie.
        order_q.delete();
        ls_wr_in = 1'b0; ls_len_in = 2'b00; ls_addr_in = 32'h302; ls_req_in = 1'b1; ls_left = 1;
        exp_ls_q.push_back('{is_wr: 1'b0, len: 2'b00, addr: 32'h302, data: 32'h0000_00FF});
        if_addr_in = 32'h0; if_req_in = 1'b1; if_left = 1;
        exp_if_q.push_back(32'h4433_2211);
        run_txns(40, if_cyc, ls_cyc);
        check("post_reset_ls_first", ls_cyc, 32'd3);
        check("post_reset_if_next", if_cyc, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory controller sitting between the CPU core and the system memory bus (RAM plus memory-mapped I/O at address bits [17:16] = 2'b11). Arbitrates the instruction-fetch unit (32-bit word reads) and the load/store unit (1/2/4-byte reads and writes) onto the single 8-bit bus. Serialises each access into byte beats, assembles read data, stalls I/O writes on `io_buffer_full`, and freezes on `rdy_in`.

## Interface
- `ADDR_W`, 32, bus address width
- `IO_SEL_HI`, 17, upper bit of the 2-bit I/O region decode ([IO_SEL_HI:IO_SEL_HI-1] == 2'b11 selects I/O)
- `clk_in` in 1: single clock. All logic is on the rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: 0 means the bus is borrowed by the host interface; the controller freezes.
- `clear_in` in 1: pipeline flush; aborts in-flight fetches and data reads.
- `if_req_in` in 1 / `if_addr_in` in 32: fetch request, held high until done.
- `if_done_out` out 1 / `if_data_out` out 32: one-cycle done pulse with the little-endian word.
- `ls_req_in` in 1, `ls_wr_in` in 1, `ls_len_in` in 2, `ls_addr_in` in 32, `ls_wdata_in` in 32: data request, held until done. `ls_len_in` encodes 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is illegal.
- `ls_done_out` out 1 / `ls_rdata_out` out 32: done pulse with read data, zero-extended.
- `mem_din` in 8: read byte, valid one cycle after its address.
- `mem_dout` out 8, `mem_a` out 32, `mem_wr` out 1: registered bus outputs.
- `io_buffer_full` in 1: the I/O output buffer is full.

## Operation
- **States:** IDLE, READ, WRITE.
- **Grant:** taken only in IDLE with `rdy_in`=1.
  - Load/store has priority.
  - Exception: if the previous grant was load/store and `if_req_in` is high, fetch wins. This alternates and prevents fetch starvation.
  - There is no preemption of a transaction in progress.
- **Latching:** on grant, latch the requester, address, length n (fetch n=4), write data, and direction.
- **Beats:** beat k drives `mem_a`=addr+k (32-bit wrap).
  - Writes: `mem_dout`=wdata[8k+7:8k] and `mem_wr`=1.
  - Reads: `mem_wr`=0.
- **Read assembly:** byte k is sampled from `mem_din` in the cycle after beat k and placed at data[8k+7:8k]. Bytes ≥ n are 0.
- **I/O write stall:** before issuing each write beat whose address is in the I/O region, wait while `io_buffer_full`=1.
  - While waiting, drive `mem_wr`=0 and `mem_a`=0.
  - Then issue the beat.
- **`rdy_in`=0:**
  - Counters, state and latched data hold; `mem_wr` is forced to 0.
  - A beat is committed only in a cycle with `rdy_in`=1. Uncommitted write beats are re-driven.
  - A read that had a beat outstanding restarts from byte 0 when `rdy_in` returns.
- **`clear_in`=1:**
  - A fetch or data read in progress or being granted is aborted. The state goes to IDLE and no done pulse is issued.
  - Writes are never aborted.
  - A done pulse already registered in the same cycle still appears.
- **Reset:** state IDLE, last-grant = fetch.
  - All outputs reset to 0: `mem_a`, `mem_dout`, `mem_wr`, both done pulses, both data buses.
- **Idle bus:** `mem_a`=0, `mem_wr`=0.

## Timing
- Cycle 0 is the grant cycle. Beat k is on the bus in cycle k+1.
- Read of n bytes: last byte is on `mem_din` in cycle n+1. Done pulse plus data are in cycle n+2. A 4-byte fetch therefore takes 6 cycles from grant to done.
- Write of n bytes: done pulse in cycle n+1, plus any stall cycles.
- The done cycle is IDLE, so a new request may be granted in that same cycle, giving back-to-back transactions.
- Done outputs are 1-cycle pulses. The data outputs hold their value until the next done pulse.
- Simultaneous `if_req_in` and `ls_req_in`: see the grant rule. A request deasserted before done is a protocol violation.

## Structure
- **Shared package `mem_ctrl_pkg`:**
  - state enum
  - `ls_len` encoding constants (LEN_B, LEN_H, LEN_W)
  - I/O region decode constant 2'b11
- **Single module.** No sub-module; the grant logic is small enough to live inline.

## Test plan
- **Fetch, read path:** RAM[0x100..0x103] = 13 05 00 00, `if_req_in` @0x100 → `if_done_out` 6 cycles after grant, `if_data_out`=0x00000513.
- **Simultaneous grant:** `ls_req_in` (write, len 10, 0x200, 0xDEADBEEF) and `if_req_in` @0x0 together, last-grant=fetch → store granted first. RAM[0x200..0x203]=EF BE AD DE, `ls_done_out` cycle 5. Fetch is granted in that cycle.
- **Fairness:** continuous `ls_req_in` plus `if_req_in` → grants alternate LS, IF, LS, IF.
- **Halfword read:** RAM[0x301]=0x80, RAM[0x302]=0xFF, read len 01 @0x301 → `ls_rdata_out`=0x0000FF80, done cycle 4.
- **I/O stall:** byte write 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles → `mem_wr` stays 0 for those 3 cycles. One write beat is issued after the flag drops, and done follows 1 cycle later.
- **Freeze and flush:**
  - `rdy_in` low for 2 cycles mid-fetch → read restarts at byte 0 and data is correct.
  - `clear_in` mid-fetch → no `if_done_out`, bus idle next cycle.
  - Reset mid-write → all outputs 0 the next cycle.
